fpu_result_stage: RTL and testbench

//  Registered output stage directly downstream of the combinational fp32 subtraction unit.

---
 rtl/fpu_pkg.sv | 20 ++
 rtl/fpu_result_fifo.sv | 56 +++++
 rtl/fpu_result_stage.sv | 122 ++++++++++++
 tb/tb_fpu_result_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared fp32 field layout, per-entry exception flags and fp32 constants
// for the FPU result path.
package fpu_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] frac;
  } fp32_t;

  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
  } fpu_flags_t;

  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;

endpackage

// File: rtl/fpu_result_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO; pushes while full and pops while
// empty are ignored. DEPTH must be a power of two so the pointers wrap naturally.
module fpu_result_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == DEPTH[AW:0]);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset; reads are only meaningful when not empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fpu_result_stage.sv
// Registered fp32 subtract result stage: IEEE fix-up, in-order FIFO, sticky flags.
// Optional FPU_RESULT_CNT_EN adds saturating overflow/underflow event counters.
module fpu_result_stage
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_result,
  input  logic             in_overflow,
  input  logic             in_underflow,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [2:0]       out_flags,
  output logic [TAG_W-1:0] out_tag,
  input  logic             flags_clr,
  output logic [2:0]       sticky_flags
`ifdef FPU_RESULT_CNT_EN
  ,
  output logic [15:0]      of_count,
  output logic [15:0]      uf_count
`endif
);

  localparam int unsigned EW = 32 + 3 + TAG_W;

  fp32_t            in_fp;
  logic [31:0]      fix_result;
  fpu_flags_t       fix_flags;
  logic             push, full, empty;
  logic [EW-1:0]    head;
  logic [31:0]      head_result;
  logic [2:0]       head_flags;
  logic [TAG_W-1:0] head_tag;
  logic [2:0]       sticky_q;

  assign in_fp = in_result;

  // Overflow takes priority over underflow and NaN canonicalisation.
  always_comb begin
    fix_result = in_result;
    fix_flags  = '0;
    if (in_overflow) begin
      fix_result   = {in_fp.sign, FP32_EXP_MAX, 23'h0};
      fix_flags.of = 1'b1;
      fix_flags.uf = in_underflow;
    end else if (in_underflow) begin
      fix_result   = {in_fp.sign, 31'h0};
      fix_flags.uf = 1'b1;
    end else if (in_fp.exp == FP32_EXP_MAX && in_fp.frac != '0) begin
      fix_result   = FP32_QNAN;
      fix_flags.nv = 1'b1;
    end
  end

  assign in_ready = !full;
  assign push     = in_valid && !full;

  fpu_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({fix_result, fix_flags, in_tag}),
    .pop   (out_ready),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign {head_result, head_flags, head_tag} = head;
  assign out_valid  = !empty;
  assign out_result = empty ? '0 : head_result;
  assign out_flags  = empty ? '0 : head_flags;
  assign out_tag    = empty ? '0 : head_tag;

  // A push coinciding with a clear leaves the new entry's flags set.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
    end else if (push) begin
      sticky_q <= (flags_clr ? 3'b000 : sticky_q) | fix_flags;
    end else if (flags_clr) begin
      sticky_q <= '0;
    end
  end

  assign sticky_flags = sticky_q;

`ifdef FPU_RESULT_CNT_EN
  logic [15:0] of_count_q, uf_count_q;
  logic        of_inc, uf_inc;

  assign of_inc = push && fix_flags.of;
  assign uf_inc = push && fix_flags.uf;

  always_ff @(posedge clk) begin
    if (rst) begin
      of_count_q <= '0;
      uf_count_q <= '0;
    end else if (flags_clr) begin
      of_count_q <= {15'h0, of_inc};
      uf_count_q <= {15'h0, uf_inc};
    end else begin
      if (of_inc && of_count_q != 16'hFFFF) of_count_q <= of_count_q + 16'd1;
      if (uf_inc && uf_count_q != 16'hFFFF) uf_count_q <= uf_count_q + 16'd1;
    end
  end

  assign of_count = of_count_q;
  assign uf_count = uf_count_q;
`endif

endmodule

// File: tb/tb_fpu_result_stage.sv
// Directed self-checking bench for fpu_result_stage (default DEPTH=2, TAG_W=4).
module tb_fpu_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_result;
  logic        in_overflow, in_underflow;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;
  logic [3:0]  out_tag;
  logic        flags_clr;
  logic [2:0]  sticky_flags;
`ifdef FPU_RESULT_CNT_EN
  logic [15:0] of_count, uf_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fpu_result_stage #(
    .DEPTH (2),
    .TAG_W (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_overflow  (in_overflow),
    .in_underflow (in_underflow),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .out_tag      (out_tag),
    .flags_clr    (flags_clr),
    .sticky_flags (sticky_flags)
`ifdef FPU_RESULT_CNT_EN
    ,
    .of_count     (of_count),
    .uf_count     (uf_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] res, input logic of, input logic uf,
                       input logic [3:0] tag);
    in_valid     = 1'b1;
    in_result    = res;
    in_overflow  = of;
    in_underflow = uf;
    in_tag       = tag;
  endtask

  task automatic push_one(input logic [31:0] res, input logic of, input logic uf,
                          input logic [3:0] tag);
    drive(res, of, uf, tag);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_result = '0; in_overflow = 1'b0;
    in_underflow = 1'b0; in_tag = '0; out_ready = 1'b1; flags_clr = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_sticky", {29'h0, sticky_flags}, 32'h0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_out_tag", {28'h0, out_tag}, 32'h0);
    check("rst_out_flags", {29'h0, out_flags}, 32'h0);

    // Passthrough, with no same-cycle path to the output
    drive(32'h3FCCCCCD, 1'b0, 1'b0, 4'h1);
    #2;
    check("pass_no_comb", {31'h0, out_valid}, 32'h0);
    step();
    in_valid = 1'b0;
    check("pass_valid", {31'h0, out_valid}, 32'h1);
    check("pass_result", out_result, 32'h3FCCCCCD);
    check("pass_flags", {29'h0, out_flags}, 32'h0);
    check("pass_tag", {28'h0, out_tag}, 32'h1);

    push_one(32'hC2C86666, 1'b1, 1'b0, 4'h2);
    check("ovf_result", out_result, 32'hFF800000);
    check("ovf_flags", {29'h0, out_flags}, 32'h2);
    check("ovf_sticky", {29'h0, sticky_flags}, 32'h2);
    check("ovf_tag", {28'h0, out_tag}, 32'h2);

    push_one(32'h80000001, 1'b0, 1'b1, 4'h3);
    check("unf_result", out_result, 32'h80000000);
    check("unf_flags", {29'h0, out_flags}, 32'h1);
    check("unf_sticky", {29'h0, sticky_flags}, 32'h3);

    push_one(32'h7F800001, 1'b0, 1'b0, 4'h4);
    check("nan_result", out_result, 32'h7FC00000);
    check("nan_flags", {29'h0, out_flags}, 32'h4);
    check("nan_sticky", {29'h0, sticky_flags}, 32'h7);

    push_one(32'h3F800000, 1'b1, 1'b1, 4'h5);
    check("both_result", out_result, 32'h7F800000);
    check("both_flags", {29'h0, out_flags}, 32'h3);

    step();
    check("drain_empty", {31'h0, out_valid}, 32'h0);

    // Backpressure: third push dropped while full
    out_ready = 1'b0;
    drive(32'h40000000, 1'b0, 1'b0, 4'h6);
    step();
    check("bp_ready1", {31'h0, in_ready}, 32'h1);
    drive(32'h40400000, 1'b0, 1'b0, 4'h7);
    step();
    check("bp_ready2", {31'h0, in_ready}, 32'h0);
    drive(32'h40800000, 1'b0, 1'b0, 4'h8);
    step();
    in_valid = 1'b0;
    check("bp_full", {31'h0, in_ready}, 32'h0);
    check("bp_head1", out_result, 32'h40000000);
    check("bp_tag1", {28'h0, out_tag}, 32'h6);
    out_ready = 1'b1;
    step();
    check("bp_head2", out_result, 32'h40400000);
    check("bp_tag2", {28'h0, out_tag}, 32'h7);
    check("bp_valid2", {31'h0, out_valid}, 32'h1);
    step();
    check("bp_empty", {31'h0, out_valid}, 32'h0);
    check("bp_ready_again", {31'h0, in_ready}, 32'h1);

    // Clear and overflowed push in the same cycle
    drive(32'h3F800000, 1'b1, 1'b0, 4'h9);
    flags_clr = 1'b1;
    step();
    in_valid  = 1'b0;
    flags_clr = 1'b0;
    check("clr_vs_set", {29'h0, sticky_flags}, 32'h2);
    flags_clr = 1'b1;
    step();
    flags_clr = 1'b0;
    check("clr_only", {29'h0, sticky_flags}, 32'h0);

    // Reset with two entries queued and a push in flight
    out_ready = 1'b0;
    push_one(32'h00000001, 1'b0, 1'b1, 4'hA);
    push_one(32'h00000002, 1'b0, 1'b0, 4'hB);
    check("pre_rst_full", {31'h0, in_ready}, 32'h0);
    check("pre_rst_sticky", {29'h0, sticky_flags}, 32'h1);
    out_ready = 1'b1;
    drive(32'h7F800001, 1'b0, 1'b0, 4'hC);
    rst = 1'b1;
    step();
    check("rst_mid_valid", {31'h0, out_valid}, 32'h0);
    check("rst_mid_sticky", {29'h0, sticky_flags}, 32'h0);
    check("rst_mid_ready", {31'h0, in_ready}, 32'h1);
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    check("post_rst_valid", {31'h0, out_valid}, 32'h0);
    check("post_rst_result", out_result, 32'h0);
`ifdef FPU_RESULT_CNT_EN
    check("rst_of_count", {16'h0, of_count}, 32'h0);
    check("rst_uf_count", {16'h0, uf_count}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
